// File: rtl/newton_pkg.sv
// Shared definitions for the Newton-step Cramer datapath: FP field layout,
// sequencer state encoding and the default determinant pipeline depth.
package newton_pkg;

    localparam int unsigned FP_W                = 32;
    localparam int unsigned SIGN_BIT            = 31;
    localparam int unsigned EXP_HI              = 30;
    localparam int unsigned EXP_LO              = 23;
    localparam int unsigned DET_LATENCY_DEFAULT = 2;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    function automatic logic [FP_W-1:0] fneg(input logic [FP_W-1:0] x);
        return {~x[SIGN_BIT], x[SIGN_BIT-1:0]};
    endfunction

endpackage

// File: rtl/determinant2_2.sv
// Single-precision a*d - b*c with one final rounding (nearest-even), subnormals
// flushed to zero, followed by LATENCY output register stages.
module determinant2_2 import newton_pkg::*; #(
    parameter int unsigned LATENCY = DET_LATENCY_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] a,
    input  logic [FP_W-1:0] b,
    input  logic [FP_W-1:0] c,
    input  logic [FP_W-1:0] d,
    output logic [FP_W-1:0] result
);

    function automatic logic [47:0] sig(input logic [FP_W-1:0] x);
        return (x[EXP_HI:EXP_LO] == 8'd0) ? 48'd0 : {24'd0, 1'b1, x[22:0]};
    endfunction

    function automatic logic is_inf(input logic [FP_W-1:0] x);
        return (x[EXP_HI:EXP_LO] == 8'hFF) && (x[22:0] == 23'd0);
    endfunction

    function automatic logic is_nan(input logic [FP_W-1:0] x);
        return (x[EXP_HI:EXP_LO] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    logic [47:0]     p1, p2;
    logic [9:0]      e1, e2, ebig, sh;
    logic            s1, s2, sbig, ssml, rsign, sticky, up, inf1, inf2, invalid;
    logic [75:0]     vbig, vsml, vali, r, rn;
    logic [6:0]      lead;
    logic [23:0]     m24;
    logic [11:0]     ex;
    logic [FP_W-1:0] comb;

    always_comb begin
        p1 = sig(a) * sig(d);
        p2 = sig(b) * sig(c);
        e1 = (p1 == 48'd0) ? 10'd0 : {2'b0, a[EXP_HI:EXP_LO]} + {2'b0, d[EXP_HI:EXP_LO]};
        e2 = (p2 == 48'd0) ? 10'd0 : {2'b0, b[EXP_HI:EXP_LO]} + {2'b0, c[EXP_HI:EXP_LO]};
        s1 = a[SIGN_BIT] ^ d[SIGN_BIT];
        s2 = ~(b[SIGN_BIT] ^ c[SIGN_BIT]);
        if (e1 >= e2) begin
            ebig = e1; sh = e1 - e2; sbig = s1; ssml = s2;
            vbig = {2'b0, p1, 26'd0}; vsml = {2'b0, p2, 26'd0};
        end else begin
            ebig = e2; sh = e2 - e1; sbig = s2; ssml = s1;
            vbig = {2'b0, p2, 26'd0}; vsml = {2'b0, p1, 26'd0};
        end
        // Bits shifted out of the smaller product collapse into a sticky LSB
        if (sh >= 10'd76) begin
            vali   = '0;
            sticky = |vsml;
        end else begin
            vali   = vsml >> sh;
            sticky = |(vsml & ((76'd1 << sh) - 76'd1));
        end
        vali[0] = vali[0] | sticky;
        rsign   = sbig;
        if (sbig == ssml) begin
            r = vbig + vali;
        end else if (vbig >= vali) begin
            r = vbig - vali;
        end else begin
            r     = vali - vbig;
            rsign = ssml;
        end
        lead = '0;
        for (int i = 0; i < 76; i++) begin
            if (r[i]) lead = 7'(i);
        end
        rn  = r << (7'd75 - lead);
        up  = rn[51] & ((|rn[50:0]) | rn[52]);
        m24 = {1'b0, rn[74:52]} + {23'd0, up};
        // Bit 72 of r carries weight 2^0 of the product at exponent ebig-254
        ex  = {2'b0, ebig} + {5'b0, lead} + {11'b0, m24[23]} - 12'd199;

        inf1    = is_inf(a) | is_inf(d);
        inf2    = is_inf(b) | is_inf(c);
        invalid = is_nan(a) | is_nan(b) | is_nan(c) | is_nan(d) |
                  (inf1 && p1 == 48'd0) | (inf2 && p2 == 48'd0) |
                  (inf1 && inf2 && (s1 != s2));
        if (invalid)                   comb = 32'h7FC0_0000;
        else if (inf1)                 comb = {s1, 8'hFF, 23'd0};
        else if (inf2)                 comb = {s2, 8'hFF, 23'd0};
        else if (!rn[75])              comb = {(p1 == 48'd0 && p2 == 48'd0) & s1 & s2, 31'd0};
        else if (ex[11] || ex == 12'd0) comb = {rsign, 31'd0};
        else if (ex >= 12'd255)        comb = {rsign, 8'hFF, 23'd0};
        else                           comb = {rsign, ex[7:0], m24[22:0]};
    end

    generate
        if (LATENCY == 0) begin : g_comb
            assign result = comb;
        end else begin : g_pipe
            logic [FP_W-1:0] stage [LATENCY];
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < int'(LATENCY); i++) stage[i] <= '0;
                end else begin
                    stage[0] <= comb;
                    for (int i = 1; i < int'(LATENCY); i++) stage[i] <= stage[i-1];
                end
            end
            assign result = stage[LATENCY-1];
        end
    endgenerate

endmodule

// File: rtl/cramer_det_sequencer.sv
// Time-multiplexes one determinant2_2 over det(J) and the two Cramer numerators
// of J*dx = -F, then holds the three results behind a valid/ready handshake.
module cramer_det_sequencer import newton_pkg::*; #(
    parameter int unsigned DET_LATENCY = DET_LATENCY_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [FP_W-1:0] j11,
    input  logic [FP_W-1:0] j12,
    input  logic [FP_W-1:0] j21,
    input  logic [FP_W-1:0] j22,
    input  logic [FP_W-1:0] f1,
    input  logic [FP_W-1:0] f2,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [FP_W-1:0] det_j,
    output logic [FP_W-1:0] num_x,
    output logic [FP_W-1:0] num_y,
    output logic            singular,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam logic [4:0] LAT = 5'(DET_LATENCY);

    state_t          state;
    logic [4:0]      cnt;
    logic [FP_W-1:0] r_j11, r_j12, r_j21, r_j22, r_f1, r_f2;
    logic [FP_W-1:0] op_a, op_b, op_c, op_d, det_res;

    // cnt doubles as issue index (0..2) and as the capture timer
    always_comb begin
        op_a = r_j11;
        op_b = r_j12;
        op_c = r_j21;
        op_d = r_j22;
        if (state == ISSUE && cnt == 5'd1) begin
            op_a = fneg(r_f1);
            op_c = fneg(r_f2);
        end else if (state == ISSUE && cnt == 5'd2) begin
            op_b = fneg(r_f1);
            op_d = fneg(r_f2);
        end
    end

    determinant2_2 #(
        .LATENCY(DET_LATENCY)
    ) u_det (
        .clk   (clk),
        .rst   (rst),
        .a     (op_a),
        .b     (op_b),
        .c     (op_c),
        .d     (op_d),
        .result(det_res)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            det_j     <= '0;
            num_x     <= '0;
            num_y     <= '0;
            singular  <= 1'b0;
            r_j11     <= '0;
            r_j12     <= '0;
            r_j21     <= '0;
            r_j22     <= '0;
            r_f1      <= '0;
            r_f2      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        r_j11    <= j11;
                        r_j12    <= j12;
                        r_j21    <= j21;
                        r_j22    <= j22;
                        r_f1     <= f1;
                        r_f2     <= f2;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ISSUE;
                    end
                end
                ISSUE, WAIT: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == LAT) begin
                        det_j    <= det_res;
                        singular <= (det_res[EXP_HI:EXP_LO] == 8'd0);
                    end
                    if (cnt == LAT + 5'd1) num_x <= det_res;
                    if (cnt == LAT + 5'd2) begin
                        num_y     <= det_res;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else if (cnt == 5'd2) begin
                        state <= WAIT;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
